vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 1024x768 VGA driver. It generates horizontal and vertical timing from per-axis parameters and makes sync polarity configurable. It issues pixel requests a configurable number of cycles ahead of display-enable, to match the latency of the pixel source (frame buffer or SDRAM read path). It adds run/stop control at frame boundaries, frame/line start strobes and a frame counter, and sits between the pixel source and the VGA/HDMI output pins.

---
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/HDMI timing generator with lead-adjusted pixel requests,
// run/stop at frame boundaries, frame/line strobes and a frame counter.
module vga_timing_gen #(
    parameter int   H_SYNC   = 136,
    parameter int   H_BACK   = 160,
    parameter int   H_DISP   = 1024,
    parameter int   H_FRONT  = 24,
    parameter int   V_SYNC   = 6,
    parameter int   V_BACK   = 29,
    parameter int   V_DISP   = 768,
    parameter int   V_FRONT  = 3,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   REQ_LEAD = 1,
    parameter int   CNT_W    = 12,
    parameter int   DATA_W   = 16
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic              run,
    input  logic [DATA_W-1:0] pixel_data,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [DATA_W-1:0] vga_rgb,
    output logic              data_req,
    output logic [CNT_W-1:0]  pixel_xpos,
    output logic [CNT_W-1:0]  pixel_ypos,
    output logic              frame_start,
    output logic              line_start,
    output logic [15:0]       frame_cnt,
    output logic              busy
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA = H_SYNC + H_BACK;
    localparam int VA = V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HDE_LO  = CNT_W'(HA);
    localparam logic [CNT_W-1:0] HDE_HI  = CNT_W'(HA + H_DISP);
    localparam logic [CNT_W-1:0] VDE_LO  = CNT_W'(VA);
    localparam logic [CNT_W-1:0] VDE_HI  = CNT_W'(VA + V_DISP);
    localparam logic [CNT_W-1:0] HREQ_LO = CNT_W'(HA - REQ_LEAD);
    localparam logic [CNT_W-1:0] HREQ_HI = CNT_W'(HA + H_DISP - REQ_LEAD);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_h, cnt_v;
    logic             act, last_h, last_v, v_win, de_d, req_d;

    always_comb begin
        act    = state == ACTIVE;
        last_h = cnt_h == H_LAST;
        last_v = cnt_v == V_LAST;
        v_win  = cnt_v >= VDE_LO && cnt_v < VDE_HI;
        de_d   = act && v_win && cnt_h >= HDE_LO && cnt_h < HDE_HI;
        // request window is the display window shifted early by the source latency
        req_d  = act && v_win && cnt_h >= HREQ_LO && cnt_h < HREQ_HI;
    end

    assign vga_rgb = vga_de ? pixel_data : '0;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            cnt_h       <= '0;
            cnt_v       <= '0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_de      <= 1'b0;
            data_req    <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
        end else begin
            vga_hs      <= (act && cnt_h < HS_END) ? HS_POL : ~HS_POL;
            vga_vs      <= (act && cnt_v < VS_END) ? VS_POL : ~VS_POL;
            vga_de      <= de_d;
            data_req    <= req_d;
            pixel_xpos  <= req_d ? cnt_h - HREQ_LO : '0;
            pixel_ypos  <= req_d ? cnt_v - VDE_LO : '0;
            frame_start <= act && cnt_h == '0 && cnt_v == '0;
            line_start  <= act && cnt_h == '0;
            frame_cnt   <= frame_cnt + 16'(act && cnt_h == '0 && cnt_v == '0);
            busy        <= act;
            if (act) begin
                cnt_h <= last_h ? '0 : cnt_h + 1'b1;
                if (last_h)
                    cnt_v <= last_v ? '0 : cnt_v + 1'b1;
                if (last_h && last_v && !run)
                    state <= IDLE;
            end else if (run) begin
                state <= ACTIVE;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a 17x9 small-timing configuration
// plus a second instance with high-active syncs and a request lead equal to the back-porch end.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, run = 1'b0, rst2 = 1'b1, run2 = 1'b0;
    logic [7:0] pix, d1, d2, rgb, x, y, rgb2, x2, y2;
    logic hs, vs, de, req, fs, ls, busy, hs2, vs2, de2, req2, fs2, ls2, busy2;
    logic [15:0] fc, fc2;
    int checks = 0, errors = 0;
    logic [7:0] q[$];

    typedef struct packed {
        logic hs, vs, de, req;
        logic [7:0] x, y;
        logic fs, ls, busy;
    } obs_t;

    obs_t obs, obs2;
    assign obs  = {hs, vs, de, req, x, y, fs, ls, busy};
    assign obs2 = {hs2, vs2, de2, req2, x2, y2, fs2, ls2, busy2};

    // pixel source: returns {ypos,xpos} two cycles after each request
    always @(posedge clk) begin
        d1 <= req ? {y[3:0], x[3:0]} : 8'h00;
        d2 <= d1;
    end
    assign pix = d2;

    vga_timing_gen #(
        .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(2), .CNT_W(8), .DATA_W(8)
    ) u_dut (
        .vga_clk(clk), .sys_rst(rst), .run(run), .pixel_data(pix),
        .vga_hs(hs), .vga_vs(vs), .vga_de(de), .vga_rgb(rgb), .data_req(req),
        .pixel_xpos(x), .pixel_ypos(y), .frame_start(fs), .line_start(ls),
        .frame_cnt(fc), .busy(busy)
    );

    vga_timing_gen #(
        .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(7), .CNT_W(8), .DATA_W(8)
    ) u_pol (
        .vga_clk(clk), .sys_rst(rst2), .run(run2), .pixel_data(8'hA5),
        .vga_hs(hs2), .vga_vs(vs2), .vga_de(de2), .vga_rgb(rgb2), .data_req(req2),
        .pixel_xpos(x2), .pixel_ypos(y2), .frame_start(fs2), .line_start(ls2),
        .frame_cnt(fc2), .busy(busy2)
    );

    // expected outputs for output cycle k of a running frame (17 cycles/line, 9 lines/frame)
    function automatic obs_t model(int k, logic pol, int lead);
        int h = k % 17;
        int v = (k / 17) % 9;
        int lo = 7 - lead;
        obs_t m;
        m.hs   = (h < 4) ? pol : ~pol;
        m.vs   = (v < 2) ? pol : ~pol;
        m.de   = h >= 7 && h < 15 && v >= 4 && v < 8;
        m.req  = h >= lo && h < lo + 8 && v >= 4 && v < 8;
        m.x    = m.req ? 8'(h - lo) : 8'd0;
        m.y    = m.req ? 8'(v - 4) : 8'd0;
        m.fs   = h == 0 && v == 0;
        m.ls   = h == 0;
        m.busy = 1'b1;
        return m;
    endfunction

    function automatic obs_t idle(logic pol);
        obs_t m = '0;
        m.hs = ~pol;
        m.vs = ~pol;
        return m;
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (obs !== idle(1'b0)) begin errors++; $display("FAIL reset_outputs got %h expected %h", obs, idle(1'b0)); end
        checks++; if (fc !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d expected 0", fc); end
        checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb got %h expected 00", rgb); end
        checks++; if (obs2 !== idle(1'b1)) begin errors++; $display("FAIL reset_pol_outputs got %h expected %h", obs2, idle(1'b1)); end
    endtask

    task automatic test_sync_timing;
        int n, nh = 0, nv = 0, nf = 0, nr = 0;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        for (n = 1; n <= 10; n++) begin @(negedge clk); if (fs) break; end
        checks++; if (n !== 2) begin errors++; $display("FAIL start_latency got %0d cycles expected 2", n); end
        for (int k = 0; k < 459; k++) begin
            if (k != 0) @(negedge clk);
            checks++; if (obs !== model(k, 1'b0, 2)) begin errors++; $display("FAIL timing k=%0d got %h expected %h", k, obs, model(k, 1'b0, 2)); end
            checks++; if (fc !== 16'(k / 153 + 1)) begin errors++; $display("FAIL frame_cnt k=%0d got %0d expected %0d", k, fc, k / 153 + 1); end
            nh += int'(!hs);
            nv += int'(!vs);
            nf += int'(fs);
            nr += int'(req);
        end
        checks++; if (nh !== 108) begin errors++; $display("FAIL hs_low_count got %0d expected 108", nh); end
        checks++; if (nv !== 102) begin errors++; $display("FAIL vs_low_count got %0d expected 102", nv); end
        checks++; if (nf !== 3) begin errors++; $display("FAIL frame_start_count got %0d expected 3", nf); end
        checks++; if (nr !== 96) begin errors++; $display("FAIL req_count got %0d expected 96", nr); end
        checks++; if (fc !== 16'd3) begin errors++; $display("FAIL frame_cnt_3 got %0d expected 3", fc); end
    endtask

    task automatic test_pixel_path;
        obs_t m;
        logic [7:0] e;
        int nde = 0;
        for (int k = 0; k < 153; k++) begin
            @(negedge clk);
            m = model(k, 1'b0, 2);
            checks++; if (obs !== m) begin errors++; $display("FAIL pix_timing k=%0d got %h expected %h", k, obs, m); end
            if (m.req) q.push_back({m.y[3:0], m.x[3:0]});
            if (m.de) begin
                nde++;
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rgb_underflow k=%0d got %h expected queued pixel", k, rgb); end
                else begin
                    e = q.pop_front();
                    if (rgb !== e) begin errors++; $display("FAIL rgb k=%0d got %h expected %h", k, rgb, e); end
                end
            end else begin
                checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL rgb_blank k=%0d got %h expected 00", k, rgb); end
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rgb_leftover got %0d expected 0", q.size()); end
        checks++; if (nde !== 32) begin errors++; $display("FAIL de_count got %0d expected 32", nde); end
    endtask

    task automatic test_run_stop;
        int n;
        for (int k = 0; k < 153; k++) begin
            @(negedge clk);
            checks++; if (obs !== model(k, 1'b0, 2)) begin errors++; $display("FAIL stop_timing k=%0d got %h expected %h", k, obs, model(k, 1'b0, 2)); end
            checks++; if (fc !== 16'd5) begin errors++; $display("FAIL stop_frame_cnt k=%0d got %0d expected 5", k, fc); end
            if (k == 50) run = 1'b0;
            if (k == 80) run = 1'b1;
            if (k == 90) run = 1'b0;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if (obs !== idle(1'b0)) begin errors++; $display("FAIL stopped k=%0d got %h expected %h", k, obs, idle(1'b0)); end
            checks++; if (fc !== 16'd5 || rgb !== 8'h00) begin errors++; $display("FAIL stopped_cnt k=%0d got %0d/%h expected 5/00", k, fc, rgb); end
        end
        run = 1'b1;
        for (n = 1; n <= 10; n++) begin @(negedge clk); if (fs) break; end
        checks++; if (n !== 2) begin errors++; $display("FAIL restart_latency got %0d cycles expected 2", n); end
        checks++; if (fc !== 16'd6) begin errors++; $display("FAIL restart_frame_cnt got %0d expected 6", fc); end
    endtask

    task automatic test_mid_reset;
        int n;
        for (int k = 1; k <= 74; k++) begin
            @(negedge clk);
            checks++; if (obs !== model(k, 1'b0, 2)) begin errors++; $display("FAIL pre_reset k=%0d got %h expected %h", k, obs, model(k, 1'b0, 2)); end
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (obs !== idle(1'b0)) begin errors++; $display("FAIL mid_reset got %h expected %h", obs, idle(1'b0)); end
            checks++; if (fc !== 16'd0 || rgb !== 8'h00) begin errors++; $display("FAIL mid_reset_cnt got %0d/%h expected 0/00", fc, rgb); end
        end
        rst = 1'b0;
        for (n = 1; n <= 10; n++) begin @(negedge clk); if (fs) break; end
        checks++; if (n !== 2) begin errors++; $display("FAIL post_reset_latency got %0d cycles expected 2", n); end
        for (int k = 0; k < 153; k++) begin
            if (k != 0) @(negedge clk);
            checks++; if (obs !== model(k, 1'b0, 2)) begin errors++; $display("FAIL post_reset k=%0d got %h expected %h", k, obs, model(k, 1'b0, 2)); end
            checks++; if (fc !== 16'd1) begin errors++; $display("FAIL post_reset_cnt k=%0d got %0d expected 1", k, fc); end
        end
    endtask

    task automatic test_polarity;
        int n;
        obs_t m;
        rst2 = 1'b0;
        run2 = 1'b1;
        for (n = 1; n <= 10; n++) begin @(negedge clk); if (fs2) break; end
        checks++; if (n !== 2) begin errors++; $display("FAIL pol_start_latency got %0d cycles expected 2", n); end
        for (int k = 0; k < 153; k++) begin
            if (k != 0) @(negedge clk);
            m = model(k, 1'b1, 7);
            checks++; if (obs2 !== m) begin errors++; $display("FAIL pol_timing k=%0d got %h expected %h", k, obs2, m); end
            checks++; if (rgb2 !== (m.de ? 8'hA5 : 8'h00)) begin errors++; $display("FAIL pol_rgb k=%0d got %h expected %h", k, rgb2, m.de ? 8'hA5 : 8'h00); end
            checks++; if (fc2 !== 16'd1) begin errors++; $display("FAIL pol_frame_cnt k=%0d got %0d expected 1", k, fc2); end
        end
    endtask

    initial begin
        test_reset;
        test_sync_timing;
        test_pixel_path;
        test_run_stop;
        test_mid_reset;
        test_polarity;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
